alu_vector_sequencer: RTL



---
 rtl/alu_pkg.sv | 34 +++
 rtl/lfsr32.sv | 39 +++
 rtl/alu_vector_sequencer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared limits, types and LFSR helpers for the ALU stimulus path.
// Owned here so every block agrees on WIDTH/SETS bounds.
package alu_pkg;

    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 1024;
    localparam int WIDTH_WARN = 256;
    localparam int SETS_MIN   = 1;
    localparam int SETS_MAX   = 1000;
    localparam int SETS_WARN  = 500;
    localparam int OPS_MIN    = 1;
    localparam int OPS_MAX    = 16;

    typedef logic [3:0] opcode_t;

    // x^32 + x^22 + x^2 + x + 1 -> feedback from bits 31, 21, 1, 0
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_e;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return {s[30:0], ^(s & LFSR_TAPS)};
    endfunction

    // An all-zero state would lock up, so a zero seed becomes 1.
    function automatic logic [31:0] fix_seed(input logic [31:0] s);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/lfsr32.sv
// 32-bit Fibonacci LFSR with seed load and step enable.
// Load wins over step; reset also returns to the seed.
module lfsr32
    import alu_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        step_i,
    output logic [31:0] state_o
);

    localparam logic [31:0] INIT = fix_seed(SEED);

    logic [31:0] state_q;
    logic [31:0] state_d;

    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = INIT;
        end else if (step_i) begin
            state_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/alu_vector_sequencer.sv
// Emits SETS operand/opcode vectors over valid/ready after a start pulse.
// Every output comes straight from a flop; the LFSRs hold the current vector.
module alu_vector_sequencer
    import alu_pkg::*;
#(
    parameter int          WIDTH  = 8,
    parameter int          SETS   = 16,
    parameter int          OPS    = 4,
    parameter logic [31:0] SEED_A = 32'h0000_0001,
    parameter logic [31:0] SEED_B = 32'h0000_ACE1,
    localparam int         IDXW   = (SETS > 1) ? $clog2(SETS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             vec_ready,
    output logic             vec_valid,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    output logic [3:0]       opcode,
    output logic [IDXW-1:0]  set_idx,
    output logic             busy,
    output logic             done
);

    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_err
        $error("WIDTH=%0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
    end else if (WIDTH > WIDTH_WARN) begin : g_width_warn
        $warning("WIDTH=%0d above %0d", WIDTH, WIDTH_WARN);
    end

    if (SETS < SETS_MIN || SETS > SETS_MAX) begin : g_sets_err
        $error("SETS=%0d outside %0d..%0d", SETS, SETS_MIN, SETS_MAX);
    end else if (SETS > SETS_WARN) begin : g_sets_warn
        $warning("SETS=%0d above %0d", SETS, SETS_WARN);
    end

    if (OPS < OPS_MIN || OPS > OPS_MAX) begin : g_ops_err
        $error("OPS=%0d outside %0d..%0d", OPS, OPS_MIN, OPS_MAX);
    end

    // Bit i of an operand is LFSR bit i mod 32 (truncate or replicate).
    function automatic logic [WIDTH-1:0] rep_op(input logic [31:0] s);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = s[i % 32];
        end
        return r;
    endfunction

    state_e           state_q;
    logic             valid_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    opcode_t          opcode_q;
    logic [IDXW-1:0]  set_idx_q;

    logic [31:0] a_state;
    logic [31:0] b_state;
    logic        load;
    logic        hs;
    logic        last;
    logic        step;

    assign load = (state_q == ST_IDLE) & start;
    assign hs   = valid_q & vec_ready;
    assign last = (set_idx_q == IDXW'(SETS - 1));
    assign step = hs & ~last;

    lfsr32 #(.SEED(SEED_A)) u_lfsr_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .state_o(a_state)
    );

    lfsr32 #(.SEED(SEED_B)) u_lfsr_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .state_o(b_state)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            opcode_q  <= '0;
            set_idx_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q   <= ST_RUN;
                        valid_q   <= 1'b1;
                        busy_q    <= 1'b1;
                        op_a_q    <= rep_op(fix_seed(SEED_A));
                        op_b_q    <= rep_op(fix_seed(SEED_B));
                        opcode_q  <= '0;
                        set_idx_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (hs && last) begin
                        state_q   <= ST_DONE;
                        valid_q   <= 1'b0;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                        op_a_q    <= '0;
                        op_b_q    <= '0;
                        opcode_q  <= '0;
                        set_idx_q <= '0;
                    end else if (hs) begin
                        // Preview the LFSR step so the operands stay registered.
                        op_a_q    <= rep_op(lfsr_next(a_state));
                        op_b_q    <= rep_op(lfsr_next(b_state));
                        set_idx_q <= set_idx_q + 1'b1;
                        opcode_q  <= (opcode_q == opcode_t'(OPS - 1))
                                     ? '0 : opcode_q + 4'd1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign vec_valid = valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign op_a      = op_a_q;
    assign op_b      = op_b_q;
    assign opcode    = opcode_q;
    assign set_idx   = set_idx_q;

endmodule
